// File: rtl/tdm_demux_14_pkg.sv
// Shared types and frame geometry for the tdm_demux_14 receive demux.
// TDM_DEMUX_PARITY_EN adds a fifth (parity) slot to every frame.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_e;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int NUM_SLOTS = 5;
`else
    localparam int NUM_SLOTS = 4;
`endif

    localparam int SEL_W = $clog2(NUM_SLOTS);

endpackage

// File: rtl/tdm_demux_14_if.sv
// Sample/frame bundle between the link front end and the demux.
// par_err only exists when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux_14_if
    import tdm_demux_pkg::*;
#(
    parameter int W = 1
);
    logic [W-1:0]     din;
    logic             din_valid;
    logic             sof;
    logic [4*W-1:0]   Y;
    logic             frame_valid;
    logic [SEL_W-1:0] sel;
    logic             locked;
    logic             sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic             par_err;

    modport master (
        output din, din_valid, sof,
        input  Y, frame_valid, sel, locked, sync_err, par_err
    );
    modport slave (
        input  din, din_valid, sof,
        output Y, frame_valid, sel, locked, sync_err, par_err
    );
`else
    modport master (
        output din, din_valid, sof,
        input  Y, frame_valid, sel, locked, sync_err
    );
    modport slave (
        input  din, din_valid, sof,
        output Y, frame_valid, sel, locked, sync_err
    );
`endif
endinterface

// File: rtl/tdm_demux_14_slot_ctr.sv
// Slot counter for the demux: tracks which slot the next sample fills.
// Clear beats load-to-1, which beats increment; wraps after the last slot.
module tdm_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             load1_i,
    input  logic             clr_i,
    output logic [SEL_W-1:0] sel_o
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SLOTS - 1);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    // Next slot index from the control strobes.
    always_comb begin
        sel_d = sel_q;
        if (clr_i) begin
            sel_d = '0;
        end else if (load1_i) begin
            sel_d = SEL_W'(1);
        end else if (inc_i) begin
            sel_d = (sel_q == LAST) ? '0 : sel_q + SEL_W'(1);
        end
    end

    // Slot index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel_o = sel_q;
endmodule

// File: rtl/tdm_demux_14.sv
// 1:4 TDM demux: reassembles sof-delimited frames and checks alignment.
// TDM_DEMUX_PARITY_EN appends an even-parity slot that gates Y updates.
module tdm_demux_14
    import tdm_demux_pkg::*;
#(
    parameter int W = 1
)(
    input  logic          clk,
    input  logic          rst,
    tdm_demux_14_if.slave bus
);
    localparam int SHW = (NUM_SLOTS - 1) * W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SLOTS - 1);

    state_e         state_q, state_d;
    logic [SHW-1:0] shadow_q, shadow_d;
    logic [4*W-1:0] y_q, y_d;
    logic           fv_q, fv_d;
    logic           se_q, se_d;
    logic           inc, load1, clr;
    logic [SEL_W-1:0] sel;
`ifdef TDM_DEMUX_PARITY_EN
    logic           pe_q, pe_d;
    logic [W-1:0]   par;
`endif

    tdm_slot_ctr u_ctr (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc),
        .load1_i (load1),
        .clr_i   (clr),
        .sel_o   (sel)
    );

`ifdef TDM_DEMUX_PARITY_EN
    // Even parity over the four data slots held in the shadow.
    always_comb begin
        par = '0;
        for (int k = 0; k < 4; k++) begin
            par = par ^ shadow_q[k*W +: W];
        end
    end
`endif

    // Per-sample decision: slot capture, alignment checks, frame completion.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        y_d      = y_q;
        fv_d     = 1'b0;
        se_d     = 1'b0;
        inc      = 1'b0;
        load1    = 1'b0;
        clr      = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        pe_d     = 1'b0;
`endif
        if (bus.din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.sof) begin
                        shadow_d[W-1:0] = bus.din;
                        load1           = 1'b1;
                        state_d         = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.sof) begin
                        // Early sof abandons the partial frame.
                        se_d            = (sel != '0);
                        shadow_d[W-1:0] = bus.din;
                        load1           = 1'b1;
                    end else if (sel == '0) begin
                        se_d    = 1'b1;
                        clr     = 1'b1;
                        state_d = HUNT;
                    end else if (sel == LAST) begin
                        inc = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                        if (par == bus.din) begin
                            y_d  = shadow_q;
                            fv_d = 1'b1;
                        end else begin
                            pe_d = 1'b1;
                        end
`else
                        y_d  = {bus.din, shadow_q};
                        fv_d = 1'b1;
`endif
                    end else begin
                        inc = 1'b1;
                        for (int k = 1; k < NUM_SLOTS - 1; k++) begin
                            if (sel == SEL_W'(k)) begin
                                shadow_d[k*W +: W] = bus.din;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // FSM state, shadow and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            shadow_q <= '0;
            y_q      <= '0;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            pe_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            y_q      <= y_d;
            fv_q     <= fv_d;
            se_q     <= se_d;
`ifdef TDM_DEMUX_PARITY_EN
            pe_q     <= pe_d;
`endif
        end
    end

    assign bus.Y           = y_q;
    assign bus.frame_valid = fv_q;
    assign bus.sel         = sel;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.sync_err    = se_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.par_err     = pe_q;
`endif
endmodule

// File: tb/tb_tdm_demux_14.sv
// Randomised + directed bench for tdm_demux_14 against a queue-based model.
// Builds with or without TDM_DEMUX_PARITY_EN.
module tb_tdm_demux_14;
    import tdm_demux_pkg::*;

    localparam int W = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   npass = 0;
    int   ntot = 0;
    int   cyc_n = 0;
    bit   started = 1'b0;

    tdm_demux_14_if #(.W(W)) bus ();

    tdm_demux_14 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: list of samples of the frame in progress.
    logic [W-1:0]   cur[$];
    logic [4*W-1:0] m_y = '0;
    logic           m_fv = 1'b0;
    logic           m_se = 1'b0;
    logic           m_pe = 1'b0;
    logic           m_locked = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                      name, act, exp, cyc_n);
    endtask

    always @(posedge clk) begin
        logic [W-1:0] p;
        cyc_n++;
        started = 1'b1;
        m_fv = 1'b0;
        m_se = 1'b0;
        m_pe = 1'b0;
        if (rst) begin
            m_y = '0;
            cur.delete();
            m_locked = 1'b0;
        end else if (bus.din_valid) begin
            if (!m_locked) begin
                if (bus.sof) begin
                    cur.delete();
                    cur.push_back(bus.din);
                    m_locked = 1'b1;
                end
            end else if (bus.sof) begin
                m_se = (cur.size() != 0);
                cur.delete();
                cur.push_back(bus.din);
            end else if (cur.size() == 0) begin
                m_se = 1'b1;
                m_locked = 1'b0;
            end else begin
                cur.push_back(bus.din);
                if (cur.size() == NUM_SLOTS) begin
                    p = '0;
                    for (int k = 0; k < 4; k++) p = p ^ cur[k];
                    if (NUM_SLOTS == 4 || p == cur[4]) begin
                        for (int k = 0; k < 4; k++) m_y[k*W +: W] = cur[k];
                        m_fv = 1'b1;
                    end else begin
                        m_pe = 1'b1;
                    end
                    cur.delete();
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("Y", 32'(bus.Y), 32'(m_y));
            chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
            chk("sel", 32'(bus.sel), 32'(cur.size()));
            chk("locked", 32'(bus.locked), 32'(m_locked));
            chk("sync_err", 32'(bus.sync_err), 32'(m_se));
`ifdef TDM_DEMUX_PARITY_EN
            chk("par_err", 32'(bus.par_err), 32'(m_pe));
`endif
        end
    end

    task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                         input logic r);
        @(negedge clk);
        rst = r;
        bus.din_valid = v;
        bus.sof = s;
        bus.din = d;
    endtask

    task automatic samp(input logic s, input logic [W-1:0] d);
        drive(1'b1, s, d, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, W'($urandom), 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Sends one complete frame; a matching parity slot is appended if enabled.
    task automatic send4(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d,
                         input int gap);
        samp(1'b1, a);
        repeat (gap) idle();
        samp(1'b0, b);
        repeat (gap) idle();
        samp(1'b0, c);
        repeat (gap) idle();
        samp(1'b0, d);
`ifdef TDM_DEMUX_PARITY_EN
        repeat (gap) idle();
        samp(1'b0, a ^ b ^ c ^ d);
`endif
        settle();
    endtask

    initial begin
        int t1;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.sof = 1'b0;

        // Reset with random inputs.
        repeat (2) drive(1'($urandom), 1'($urandom), W'($urandom), 1'b1);
        idle();
        settle();
        chk("reset Y", 32'(bus.Y), 32'h0);
        chk("reset locked", 32'(bus.locked), 32'h0);
        chk("reset sel", 32'(bus.sel), 32'h0);

        // Basic and back-to-back frames.
        send4(1, 0, 1, 1, 0);
        chk("basic Y", 32'(bus.Y), 32'hD);
        chk("basic fv", 32'(bus.frame_valid), 32'h1);
        chk("basic locked", 32'(bus.locked), 32'h1);
        t1 = cyc_n;
        send4(0, 1, 1, 0, 0);
        chk("b2b Y", 32'(bus.Y), 32'h6);
        chk("b2b spacing", 32'(cyc_n - t1), 32'(NUM_SLOTS));
        idle();
        settle();
        chk("fv one cycle", 32'(bus.frame_valid), 32'h0);

        // Gaps between samples.
        samp(1'b1, 1);
        idle();
        idle();
        settle();
        chk("gap sel hold", 32'(bus.sel), 32'h1);
        samp(1'b0, 0);
        idle();
        samp(1'b0, 1);
        idle();
        samp(1'b0, 1);
`ifdef TDM_DEMUX_PARITY_EN
        idle();
        samp(1'b0, 1);
`endif
        settle();
        chk("gap Y", 32'(bus.Y), 32'hD);

        // Early sof.
        samp(1'b1, 1);
        samp(1'b0, 1);
        samp(1'b1, 0);
        settle();
        chk("early sync_err", 32'(bus.sync_err), 32'h1);
        chk("early Y kept", 32'(bus.Y), 32'hD);
        samp(1'b0, 0);
        samp(1'b0, 0);
        samp(1'b0, 1);
`ifdef TDM_DEMUX_PARITY_EN
        samp(1'b0, 1);
`endif
        settle();
        chk("early Y", 32'(bus.Y), 32'h8);

        // Missing sof.
        samp(1'b0, 1);
        settle();
        chk("miss sync_err", 32'(bus.sync_err), 32'h1);
        chk("miss locked", 32'(bus.locked), 32'h0);
        samp(1'b0, 1);
        samp(1'b0, 0);
        settle();
        chk("hunt ignores", 32'(bus.sel), 32'h0);

        // Reset mid-frame.
        samp(1'b1, 1);
        samp(1'b0, 1);
        drive(1'b1, 1'b0, 1, 1'b1);
        idle();
        settle();
        chk("midrst Y", 32'(bus.Y), 32'h0);
        chk("midrst sel", 32'(bus.sel), 32'h0);

`ifdef TDM_DEMUX_PARITY_EN
        // Bad parity leaves Y unchanged.
        send4(1, 0, 1, 1, 0);
        chk("par ok Y", 32'(bus.Y), 32'hD);
        samp(1'b1, 0);
        samp(1'b0, 1);
        samp(1'b0, 1);
        samp(1'b0, 0);
        samp(1'b0, 1);
        settle();
        chk("par_err", 32'(bus.par_err), 32'h1);
        chk("par bad Y", 32'(bus.Y), 32'hD);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0),
                  W'($urandom),
                  ($urandom_range(0, 299) == 0));
        end
        idle();
        settle();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
